// File: rtl/cond_unit_it_if.sv
// Instruction/condition bus between the decode stage and the condition-execution
// unit. The master side drives the instruction fields and IT controls and reads
// back the gated write enables, the flag register and the IT status. The slave
// side is the condition unit.
//
// Signals (slave view):
//   in : valid_i, flush_i, Cond[3:0], ALUFlags[3:0] {N,Z,C,V}, FlagW[1:0],
//        PCS, RegW, MemW, NoWrite, it_start, it_cond[3:0],
//        it_len[CNT_W-1:0], it_mask[IT_MAX-1:0]
//   out: CondEx, PCSrc, RegWrite, MemWrite, Flags[3:0], it_active,
//        it_remaining[CNT_W-1:0], it_err
interface cond_unit_it_if #(
  parameter int IT_MAX = 4,
  parameter int CNT_W  = $clog2(IT_MAX + 1)
);
  logic              valid_i;
  logic              flush_i;
  logic [3:0]        Cond;
  logic [3:0]        ALUFlags;
  logic [1:0]        FlagW;
  logic              PCS;
  logic              RegW;
  logic              MemW;
  logic              NoWrite;
  logic              it_start;
  logic [3:0]        it_cond;
  logic [CNT_W-1:0]  it_len;
  logic [IT_MAX-1:0] it_mask;

  logic              CondEx;
  logic              PCSrc;
  logic              RegWrite;
  logic              MemWrite;
  logic [3:0]        Flags;
  logic              it_active;
  logic [CNT_W-1:0]  it_remaining;
  logic              it_err;

  modport master (
    output valid_i, flush_i, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
           it_start, it_cond, it_len, it_mask,
    input  CondEx, PCSrc, RegWrite, MemWrite, Flags, it_active, it_remaining,
           it_err
  );

  modport slave (
    input  valid_i, flush_i, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
           it_start, it_cond, it_len, it_mask,
    output CondEx, PCSrc, RegWrite, MemWrite, Flags, it_active, it_remaining,
           it_err
  );
endinterface

// File: rtl/cond_unit_it.sv
// Condition-execution unit with IT-block sequencer.
// Holds the NZCV flag register (split N/Z and C/V write enables), evaluates the
// ARM condition field against the registered flags and gates PCSrc, RegWrite and
// MemWrite. An IT instruction predicates up to IT_MAX following instructions
// with then/else variants of its base condition, overriding their own Cond.
//
// Ports:
//   clk   : core clock, rising edge
//   reset : synchronous, active-low
//   bus   : cond_unit_it_if.slave (instruction fields in, gated enables,
//           Flags and IT status out)
module cond_unit_it #(
  parameter int IT_MAX = 4
) (
  input  logic           clk,
  input  logic           reset,
  cond_unit_it_if.slave  bus
);
  localparam int CNT_W = $clog2(IT_MAX + 1);
  localparam logic [CNT_W-1:0] IT_MAX_C = CNT_W'(IT_MAX);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  typedef enum logic {S_IDLE, S_ACTIVE} it_state_e;

  it_state_e         state_q, state_d;
  logic [3:0]        flags_q;
  logic [3:0]        cond_q;
  logic [IT_MAX-1:0] mask_q;
  logic [IT_MAX-1:0] mask_sh;
  logic [CNT_W-1:0]  rem_q;
  logic [CNT_W-1:0]  slot_q;
  logic              err_q;

  logic in_it;
  logic then_slot;
  logic len_ok;
  logic last_slot;
  logic cond_ex;
  logic pcsrc;
  logic it_active;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, ge;
    {n, z, cy, v} = f;
    ge = (n == v);
    case (c)
      4'b0000: return z;
      4'b0001: return ~z;
      4'b0010: return cy;
      4'b0011: return ~cy;
      4'b0100: return n;
      4'b0101: return ~n;
      4'b0110: return v;
      4'b0111: return ~v;
      4'b1000: return cy & ~z;
      4'b1001: return ~cy | z;
      4'b1010: return ge;
      4'b1011: return ~ge;
      4'b1100: return ~z & ge;
      4'b1101: return z | ~ge;
      4'b1110: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign in_it     = (state_q == S_ACTIVE);
  assign mask_sh   = mask_q >> slot_q;
  assign then_slot = mask_sh[0];
  assign len_ok    = (bus.it_len != '0) && (bus.it_len <= IT_MAX_C);
  assign last_slot = (rem_q == ONE_C);

  // Inside a block the stored base condition replaces Cond; else-slots flip
  // bit0, except that AL has no inverse and so never executes as an else-slot.
  always_comb begin
    cond_ex = 1'b0;
    if (in_it) begin
      if (then_slot)
        cond_ex = cond_pass(cond_q, flags_q);
      else if (cond_q == 4'b1110)
        cond_ex = 1'b0;
      else
        cond_ex = cond_pass({cond_q[3:1], ~cond_q[0]}, flags_q);
    end else if (bus.it_start) begin
      cond_ex = 1'b1;
    end else begin
      cond_ex = cond_pass(bus.Cond, flags_q);
    end
  end

  assign pcsrc = bus.valid_i & cond_ex & bus.PCS;

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Sequencer next state
  always_comb begin
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = S_IDLE;
    end else if (bus.valid_i) begin
      case (state_q)
        S_IDLE:   if (bus.it_start && len_ok) state_d = S_ACTIVE;
        S_ACTIVE: if (last_slot || pcsrc)     state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Sequencer outputs
  always_comb begin
    it_active = 1'b0;
    if (state_q == S_ACTIVE) it_active = 1'b1;
  end

  // IT counters, latched block description and sticky error.
  // An it_start seen mid-block only consumes its slot and flags the error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rem_q  <= '0;
      slot_q <= '0;
      cond_q <= '0;
      mask_q <= '0;
      err_q  <= 1'b0;
    end else if (bus.flush_i) begin
      rem_q  <= '0;
      slot_q <= '0;
      cond_q <= '0;
      mask_q <= '0;
    end else if (bus.valid_i) begin
      if (in_it) begin
        if (last_slot || pcsrc) begin
          rem_q  <= '0;
          slot_q <= '0;
        end else begin
          rem_q  <= rem_q - ONE_C;
          slot_q <= slot_q + ONE_C;
        end
        if (bus.it_start) err_q <= 1'b1;
      end else if (bus.it_start) begin
        if (len_ok) begin
          rem_q  <= bus.it_len;
          slot_q <= '0;
          cond_q <= bus.it_cond;
          mask_q <= bus.it_mask;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  // Flag register; flush does not cancel the current instruction's update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q <= '0;
    end else if (bus.valid_i && cond_ex) begin
      if (bus.FlagW[1]) flags_q[3:2] <= bus.ALUFlags[3:2];
      if (bus.FlagW[0]) flags_q[1:0] <= bus.ALUFlags[1:0];
    end
  end

  assign bus.CondEx       = cond_ex;
  assign bus.PCSrc        = pcsrc;
  assign bus.RegWrite     = bus.valid_i & cond_ex & bus.RegW & ~bus.NoWrite;
  assign bus.MemWrite     = bus.valid_i & cond_ex & bus.MemW;
  assign bus.Flags        = flags_q;
  assign bus.it_active    = it_active;
  assign bus.it_remaining = rem_q;
  assign bus.it_err       = err_q;
endmodule

// File: tb/tb_cond_unit_it.sv
// Directed bench for cond_unit_it: expectations are queued as each instruction
// is driven and popped/compared once the DUT output for it is available.
module tb_cond_unit_it;
  localparam int IT_MAX = 4;
  localparam int CNT_W  = $clog2(IT_MAX + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cond_unit_it_if #(.IT_MAX(IT_MAX)) bif();
  cond_unit_it #(.IT_MAX(IT_MAX)) dut (.clk(clk), .reset(reset), .bus(bif));

  typedef enum int {O_CONDEX, O_PCSRC, O_REGW, O_MEMW, O_FLAGS, O_ACT, O_REM, O_ERR} sel_e;
  typedef struct {
    string      tag;
    sel_e       sel;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int ntests = 0;
  int nfail  = 0;

  function automatic logic [7:0] observe(sel_e s);
    case (s)
      O_CONDEX: return {7'd0, bif.CondEx};
      O_PCSRC:  return {7'd0, bif.PCSrc};
      O_REGW:   return {7'd0, bif.RegWrite};
      O_MEMW:   return {7'd0, bif.MemWrite};
      O_FLAGS:  return {4'd0, bif.Flags};
      O_ACT:    return {7'd0, bif.it_active};
      O_REM:    return 8'(bif.it_remaining);
      O_ERR:    return {7'd0, bif.it_err};
      default:  return 8'hxx;
    endcase
  endfunction

  task automatic push(string tag, sel_e s, logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    while (sb.size() != 0) begin
      exp_t e;
      logic [7:0] o;
      e = sb.pop_front();
      o = observe(e.sel);
      ntests++;
      assert (o === e.val) else begin
        nfail++;
        $error("FAIL %s/%s observed=%0h expected=%0h", e.tag, e.sel.name(), o, e.val);
      end
    end
  endtask

  // Combinational outputs, checked mid-cycle after inputs settle
  task automatic comb(string t, logic cx, logic pc, logic rw, logic mw);
    #1;
    push(t, O_CONDEX, {7'd0, cx});
    push(t, O_PCSRC,  {7'd0, pc});
    push(t, O_REGW,   {7'd0, rw});
    push(t, O_MEMW,   {7'd0, mw});
    drain();
  endtask

  // Registered outputs, checked just after the clock edge
  task automatic regs(string t, logic [3:0] f, logic act, logic [CNT_W-1:0] rem, logic err);
    @(posedge clk);
    #1;
    push(t, O_FLAGS, {4'd0, f});
    push(t, O_ACT,   {7'd0, act});
    push(t, O_REM,   8'(rem));
    push(t, O_ERR,   {7'd0, err});
    drain();
  endtask

  task automatic idle();
    bif.valid_i  = 1'b0;
    bif.flush_i  = 1'b0;
    bif.Cond     = 4'b1110;
    bif.ALUFlags = 4'b0000;
    bif.FlagW    = 2'b00;
    bif.PCS      = 1'b0;
    bif.RegW     = 1'b0;
    bif.MemW     = 1'b0;
    bif.NoWrite  = 1'b0;
    bif.it_start = 1'b0;
    bif.it_cond  = 4'b0000;
    bif.it_len   = '0;
    bif.it_mask  = '0;
  endtask

  task automatic instr(logic [3:0] c, logic rw);
    idle();
    bif.valid_i = 1'b1;
    bif.Cond    = c;
    bif.RegW    = rw;
  endtask

  task automatic it_instr(logic [3:0] c, logic [CNT_W-1:0] len, logic [IT_MAX-1:0] m);
    instr(4'b1110, 1'b0);
    bif.it_start = 1'b1;
    bif.it_cond  = c;
    bif.it_len   = len;
    bif.it_mask  = m;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    regs("rst", 4'b0000, 1'b0, 3'd0, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    @(posedge clk);
    #1;
    do_reset();

    // Flag register and plain condition evaluation
    instr(4'b1110, 1'b1); bif.ALUFlags = 4'b0100; bif.FlagW = 2'b11;
    comb("adds", 1, 0, 1, 0);       regs("adds", 4'b0100, 0, 0, 0);
    instr(4'b0000, 1'b1);
    comb("eq", 1, 0, 1, 0);         regs("eq", 4'b0100, 0, 0, 0);
    instr(4'b0001, 1'b1); bif.MemW = 1'b1; bif.PCS = 1'b1;
    comb("ne", 0, 0, 0, 0);         regs("ne", 4'b0100, 0, 0, 0);
    instr(4'b1110, 1'b1); bif.NoWrite = 1'b1;
    comb("nowrite", 1, 0, 0, 0);    regs("nowrite", 4'b0100, 0, 0, 0);
    instr(4'b1110, 1'b0); bif.ALUFlags = 4'b1011; bif.FlagW = 2'b01;
    comb("cv_only", 1, 0, 0, 0);    regs("cv_only", 4'b0111, 0, 0, 0);
    instr(4'b1011, 1'b0); bif.MemW = 1'b1;
    comb("lt", 1, 0, 0, 1);         regs("lt", 4'b0111, 0, 0, 0);
    instr(4'b1000, 1'b0); bif.PCS = 1'b1;
    comb("hi", 0, 0, 0, 0);         regs("hi", 4'b0111, 0, 0, 0);
    instr(4'b1111, 1'b1);
    comb("nv", 0, 0, 0, 0);         regs("nv", 4'b0111, 0, 0, 0);

    // IT EQ, 3 slots, mask then/else/then, Z=1; own Cond=AL ignored
    it_instr(4'b0000, 3'd3, 4'b0101);
    comb("it3", 1, 0, 0, 0);        regs("it3", 4'b0111, 1, 3, 0);
    instr(4'b1110, 1'b1);
    comb("it3_s0", 1, 0, 1, 0);     regs("it3_s0", 4'b0111, 1, 2, 0);
    instr(4'b1110, 1'b1);
    comb("it3_s1", 0, 0, 0, 0);     regs("it3_s1", 4'b0111, 1, 1, 0);
    instr(4'b1110, 1'b1);
    comb("it3_s2", 1, 0, 1, 0);     regs("it3_s2", 4'b0111, 0, 0, 0);
    instr(4'b0001, 1'b1);
    comb("it3_post", 0, 0, 0, 0);   regs("it3_post", 4'b0111, 0, 0, 0);

    // Taken branch ends the block early; next instruction uses its own Cond
    it_instr(4'b0000, 3'd4, 4'b1111);
    comb("it4", 1, 0, 0, 0);        regs("it4", 4'b0111, 1, 4, 0);
    instr(4'b1110, 1'b1);
    comb("it4_s0", 1, 0, 1, 0);     regs("it4_s0", 4'b0111, 1, 3, 0);
    instr(4'b1110, 1'b0); bif.PCS = 1'b1;
    comb("it4_br", 1, 1, 0, 0);     regs("it4_br", 4'b0111, 0, 0, 0);
    instr(4'b0001, 1'b1);
    comb("it4_post", 0, 0, 0, 0);   regs("it4_post", 4'b0111, 0, 0, 0);

    // AL base condition: else-slot never executes
    it_instr(4'b1110, 3'd2, 4'b0001);
    comb("ital", 1, 0, 0, 0);       regs("ital", 4'b0111, 1, 2, 0);
    instr(4'b1110, 1'b1);
    comb("ital_s0", 1, 0, 1, 0);    regs("ital_s0", 4'b0111, 1, 1, 0);
    instr(4'b1110, 1'b1);
    comb("ital_s1", 0, 0, 0, 0);    regs("ital_s1", 4'b0111, 0, 0, 0);

    // Flush cancels the block but keeps the flag update
    it_instr(4'b1110, 3'd3, 4'b0111);
    comb("itf", 1, 0, 0, 0);        regs("itf", 4'b0111, 1, 3, 0);
    instr(4'b1110, 1'b0); bif.flush_i = 1'b1; bif.FlagW = 2'b10; bif.ALUFlags = 4'b1000;
    comb("flush", 1, 0, 0, 0);      regs("flush", 4'b1011, 0, 0, 0);

    // Illegal lengths
    it_instr(4'b0000, 3'd0, 4'b1111);
    comb("len0", 1, 0, 0, 0);       regs("len0", 4'b1011, 0, 0, 1);
    do_reset();
    it_instr(4'b0000, 3'd5, 4'b1111);
    comb("len5", 1, 0, 0, 0);       regs("len5", 4'b0000, 0, 0, 1);
    do_reset();

    // Nested IT consumes the slot, flags error, updates Flags (AL then-slot)
    it_instr(4'b1110, 3'd3, 4'b0111);
    comb("itn", 1, 0, 0, 0);        regs("itn", 4'b0000, 1, 3, 0);
    it_instr(4'b0001, 3'd2, 4'b0000); bif.FlagW = 2'b11; bif.ALUFlags = 4'b1111;
    comb("nested", 1, 0, 0, 0);     regs("nested", 4'b1111, 1, 2, 1);

    // Stall holds everything and blocks the write enables
    idle(); bif.PCS = 1'b1; bif.RegW = 1'b1; bif.MemW = 1'b1;
    bif.FlagW = 2'b11; bif.ALUFlags = 4'b0000;
    comb("stall0", 1, 0, 0, 0);     regs("stall0", 4'b1111, 1, 2, 1);
    comb("stall1", 1, 0, 0, 0);     regs("stall1", 4'b1111, 1, 2, 1);

    // Reset mid-block wins over a valid instruction
    instr(4'b1110, 1'b1); bif.it_start = 1'b1; bif.it_len = 3'd1;
    bif.FlagW = 2'b11; bif.ALUFlags = 4'b0100;
    reset = 1'b0;
    regs("rst_mid", 4'b0000, 0, 0, 0);
    reset = 1'b1;
    instr(4'b0000, 1'b1);
    comb("eq_after_rst", 0, 0, 0, 0);
    regs("eq_after_rst", 4'b0000, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/cond_unit_it.md
Name: cond_unit_it

Overview:
- Next-generation condition-execution unit for the single-cycle/pipelined ARM-subset core.
- Holds the architectural NZCV flag register with split write enables.
- Evaluates the 4-bit condition field and gates PCSrc, RegWrite and MemWrite.
- Adds a parametrised IT-block sequencer: one IT instruction predicates up to IT_MAX following instructions with then/else conditions, overriding each instruction's own Cond field.

Parameters:
- IT_MAX, 4, maximum instructions predicated by one IT instruction (1..8).
- CNT_W, $clog2(IT_MAX+1), width of the IT length and remaining counters.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising clk.
- valid_i  input  1  an instruction is in this stage this cycle; all state advances only when 1.
- flush_i  input  1  pipeline flush; cancels any active IT block.
- Cond  input  4  instruction condition field (ARM encoding, 1110=AL, 1111=undefined).
- ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction.
- FlagW  input  2  [1] writes N,Z; [0] writes C,V.
- PCS  input  1  instruction writes the PC.
- RegW  input  1  instruction writes the register file.
- MemW  input  1  instruction writes memory.
- NoWrite  input  1  compare-type instruction; suppresses RegWrite.
- it_start  input  1  current instruction is an IT instruction.
- it_cond  input  4  base condition for the IT block.
- it_len  input  CNT_W  number of predicated instructions, 1..IT_MAX.
- it_mask  input  IT_MAX  bit k: 1=then (it_cond), 0=else (inverted) for slot k.
- CondEx  output  1  effective condition passed (combinational).
- PCSrc  output  1  valid_i & CondEx & PCS.
- RegWrite  output  1  valid_i & CondEx & RegW & ~NoWrite.
- MemWrite  output  1  valid_i & CondEx & MemW.
- Flags  output  4  registered {N,Z,C,V}.
- it_active  output  1  registered; an IT block is in progress.
- it_remaining  output  CNT_W  registered; slots left in the active block.
- it_err  output  1  registered, sticky; illegal IT usage detected.

Behaviour:
- Reset (reset==0 at edge): Flags=0000, it_active=0, it_remaining=0, slot index=0, stored mask/cond=0, it_err=0. Reset overrides every other input, including mid-block.
- Condition evaluation is always against registered Flags (the pre-update value). ge=(N==V).
- EQ/NE/CS/CC/MI/PL/VS/VC/HI/LS/GE/LT/GT/LE/AL use standard ARM semantics. Cond 1111 outside an IT slot gives CondEx=0.
- Effective condition:
  - If it_active, effective condition = stored it_cond when the current slot's mask bit is 1, otherwise it_cond with bit0 inverted. Cond input is ignored.
  - If the stored it_cond is AL (1110), else-slots give CondEx=0.
  - Otherwise, effective condition = Cond.
- An IT instruction itself (it_start & ~it_active) always executes: CondEx=1.
- Flag update at edge when valid_i & CondEx: FlagW[1] loads N,Z from ALUFlags; FlagW[0] loads C,V. Flags held otherwise. The update applies before the next instruction's evaluation.
- IT start at edge when valid_i & it_start & ~it_active & 1<=it_len<=IT_MAX:
  - it_active=1, it_remaining=it_len, slot=0.
  - it_cond and it_mask are latched.
- Illegal start (it_len==0 or >IT_MAX): no block starts; it_err=1.
- it_start while it_active: treated as an ordinary predicated slot (consumes the slot); it_err=1.
- Slot advance at edge when valid_i & it_active: it_remaining-=1, slot+=1. At it_remaining 1→0, it_active=0 in the same edge. Slots advance whether or not CondEx passes.
- Taken branch in a slot (PCSrc=1): the block terminates at that edge (it_active=0, it_remaining=0).
- flush_i=1 at edge: clears IT state and takes priority over start/advance. Flags update from the current instruction is still honoured if valid_i & CondEx.
- valid_i=0: no state changes; outputs PCSrc/RegWrite/MemWrite=0.

Test Plan:
- Reset, then ADDS with ALUFlags=0100 and FlagW=11 → Flags=0100 next cycle. Next instruction with Cond=0000 gives CondEx=1; with Cond=0001 gives CondEx=0.
- FlagW=01, ALUFlags=1011, Flags=0100 → Flags=0111. N,Z unchanged, C,V loaded.
- IT: it_cond=0000, it_len=3, mask=…101, Z=1. Slots give CondEx=1,0,1 regardless of Cond=1110. it_remaining goes 3,2,1,0. it_active drops after slot 3.
- IT with it_len=4; PCS=1 taken in slot 2 → PCSrc=1, it_active=0 next cycle. Slot-3 instruction evaluated with its own Cond.
- it_len=0 → it_err=1, it_active stays 0. Separately, it_start during an active block → it_err=1, slot consumed.
- Mid-block: valid_i=0 for 2 cycles holds it_remaining. Then reset=0 for one edge → Flags=0000, it_active=0, it_err=0.
